hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous reset, active low
- D_rs  in  5  rs field of the D-stage instruction
- D_rt  in  5  rt field of the D-stage instruction
- D_rs_tuse  in  2  cycles until rs is consumed (0 = D, 1 = E, 3 = unused)
- D_rt_tuse  in  2  as D_rs_tuse, for rt
- D_dst  in  5  destination register of the D-stage instruction (0 = none)
- D_tnew  in  2  result latency counted from E entry (1 = ALU, 2 = load)
- D_md_start  in  1  D-stage instruction is mult/div
- D_md_div  in  1  1 = div, 0 = mult; valid when D_md_start = 1
- D_md_use  in  1  D-stage instruction reads or writes HI/LO or starts the MD unit
- stall  out  1  freeze PC and D register, insert a bubble into E
- selA  out  2  E-stage operand A forward select (0 = GRF_r1, 1 = M, 2 = W)
- selB  out  2  E-stage operand B forward select (0 = GRF_r2, 1 = M, 2 = W)
- md_busy  out  1  MD unit busy

Function
REQ-003 Internal stage registers SHALL be:
- E: E_rs, E_rt, E_dst, E_tnew, E_md
- M: M_dst, M_tnew
- W: W_dst
REQ-004 Each rising edge with stall = 0, E SHALL load D_rs, D_rt, D_dst, D_tnew, and D_md_start.
REQ-005 Each rising edge with stall = 1, E SHALL load a bubble: every field zero.
REQ-006 Each rising edge, M SHALL load M_dst = E_dst and M_tnew = E_tnew - 1, saturating at 0.
REQ-007 Each rising edge, W SHALL load W_dst = M_dst.
REQ-008 Data stall rule, evaluated for rs and separately for rt, when the register is nonzero and its tuse is not 3: stall if (E_dst == reg and E_tnew > tuse) or (M_dst == reg and M_tnew > tuse).
REQ-009 MD stall rule: stall if D_md_use = 1 and (md_busy = 1 or E_md = 1).
REQ-010 stall SHALL be the OR of the data stall and MD stall conditions, and SHALL be combinational with no added latency.
REQ-011 selA SHALL be:
- 1 if E_rs != 0, E_rs == M_dst, and M_tnew == 0;
- else 2 if E_rs != 0 and E_rs == W_dst;
- else 0.
REQ-012 selB SHALL follow the REQ-011 rule with E_rt in place of E_rs.
REQ-013 M forwarding SHALL take priority over W forwarding when both match.
REQ-014 selA and selB SHALL be combinational from registered state and SHALL never take value 3.
REQ-015 Register 0 SHALL never cause a stall or a nonzero select.
REQ-016 MD counter (4 bits) behaviour:
- loads 5 (mult) or 10 (div) on the edge where an instruction with E_md = 1 leaves E;
- otherwise decrements by 1 when nonzero and holds at 0.
REQ-017 md_busy SHALL equal (counter != 0).
REQ-018 A mult/div reaches E only when stall = 0, so the MD unit SHALL never start twice; no overlap is possible.

Reset
REQ-019 On reset_n low, all stage registers and the MD counter SHALL clear to 0 immediately.
REQ-020 During and after reset, outputs SHALL be stall = 0, selA = 0, selB = 0, md_busy = 0.
REQ-021 Reset asserted during a mult/div SHALL abort it; after release, no residual stall.
REQ-022 After reset_n deasserts, normal operation SHALL begin on the first rising edge.

Verification
REQ-023 Scenario ALU-ALU: addu $3 (D_dst = 3, tnew = 1), then subu reading rs = 3 with tuse = 1 -> stall = 0 throughout; consumer in E with producer in M gives selA = 1.
REQ-024 Scenario load-use: lw $5 (tnew = 2), then addu with rt = 5, tuse = 1 -> stall = 1 for exactly 1 cycle; then selB = 1 if the lw is in M with tnew 0, otherwise selB = 2.
REQ-025 Scenario branch after ALU: addu $4, then beq with rs = 4, tuse = 0 -> stall = 1 for 1 cycle; no stall with a one-instruction gap.
REQ-026 Scenario MD busy: div (D_md_start = 1, D_md_div = 1), then mfhi (D_md_use = 1) -> md_busy = 1 for 10 cycles; stall = 1 from mfhi's arrival in D until md_busy falls; mult gives 5 cycles.
REQ-027 Scenario priority and $0: M_dst = W_dst = 7 with E_rs = 7 -> selA = 1; producer writes $0 and consumer reads $0 -> stall = 0 and selA = 0.
REQ-028 Scenario reset mid-div: reset_n pulsed low 3 cycles after div start -> md_busy = 0 and stall = 0 immediately; all selects 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock and forwarding control for a five-stage core.
// It detects data and mult/div stalls and drives the E-stage operand forward selects.
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_rs_tuse,
  input  logic [1:0] D_rt_tuse,
  input  logic [4:0] D_dst,
  input  logic [1:0] D_tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_md_use,
  output logic       stall,
  output logic [1:0] selA,
  output logic [1:0] selB,
  output logic       md_busy
);
  logic [4:0] E_rs, E_rt, E_dst, M_dst, W_dst;
  logic [1:0] E_tnew, M_tnew;
  logic       E_md, E_div;
  logic [3:0] md_cnt;
  logic       rs_haz, rt_haz, md_haz;
  always_comb begin
    rs_haz = D_rs != 5'd0 && D_rs_tuse != 2'd3 &&
             ((E_dst == D_rs && E_tnew > D_rs_tuse) || (M_dst == D_rs && M_tnew > D_rs_tuse));
    rt_haz = D_rt != 5'd0 && D_rt_tuse != 2'd3 &&
             ((E_dst == D_rt && E_tnew > D_rt_tuse) || (M_dst == D_rt && M_tnew > D_rt_tuse));
    md_haz = D_md_use && (md_busy || E_md);
    stall  = rs_haz || rt_haz || md_haz;
    md_busy = md_cnt != 4'd0;
    selA = (E_rs != 5'd0 && E_rs == M_dst && M_tnew == 2'd0) ? 2'd1 :
           (E_rs != 5'd0 && E_rs == W_dst) ? 2'd2 : 2'd0;
    selB = (E_rt != 5'd0 && E_rt == M_dst && M_tnew == 2'd0) ? 2'd1 :
           (E_rt != 5'd0 && E_rt == W_dst) ? 2'd2 : 2'd0;
  end
  // A stall turns the E load into a bubble; the MD counter starts as the op leaves E.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      E_rs   <= '0;
      E_rt   <= '0;
      E_dst  <= '0;
      E_tnew <= '0;
      E_md   <= 1'b0;
      E_div  <= 1'b0;
      M_dst  <= '0;
      M_tnew <= '0;
      W_dst  <= '0;
      md_cnt <= '0;
    end else begin
      E_rs   <= stall ? 5'd0 : D_rs;
      E_rt   <= stall ? 5'd0 : D_rt;
      E_dst  <= stall ? 5'd0 : D_dst;
      E_tnew <= stall ? 2'd0 : D_tnew;
      E_md   <= stall ? 1'b0 : D_md_start;
      E_div  <= stall ? 1'b0 : D_md_div;
      M_dst  <= E_dst;
      M_tnew <= E_tnew == 2'd0 ? 2'd0 : E_tnew - 2'd1;
      W_dst  <= M_dst;
      md_cnt <= E_md ? (E_div ? 4'd10 : 4'd5) : md_busy ? md_cnt - 4'd1 : 4'd0;
    end
  end
endmodule
